// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: latches a request vector and emits the index of every set bit, one beat each, in priority order.
module prio_scan_encoder #(
    parameter int WIDTH     = 16,
    parameter int IDXW      = $clog2(WIDTH),
    parameter int LOW_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              out_none,
    output logic [IDXW:0]     out_count
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    logic [WIDTH-1:0]  mask;
    logic [IDXW:0]     count;
    logic              none;
    logic [IDXW-1:0]   pick;
    logic [IDXW:0]     pop;
    logic              one_hot;
    logic              scan;
    logic              accept;
    logic              beat;

    // Later iterations overwrite earlier ones, so the last set bit visited wins.
    always_comb begin
        pick = '0;
        pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LOW_FIRST != 0)
                pick = mask[WIDTH-1-i] ? IDXW'(WIDTH-1-i) : pick;
            else
                pick = mask[i] ? IDXW'(i) : pick;
            pop = pop + (IDXW+1)'(in_vec[i]);
        end
    end

    assign one_hot   = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
    assign scan      = rst_n && (state == SCAN);
    assign out_valid = scan;
    assign out_idx   = (scan && !none) ? pick : '0;
    assign out_last  = scan && (one_hot || none);
    assign out_none  = scan && none;
    assign out_count = scan ? count : '0;
    assign beat      = out_valid && out_ready;
    assign in_ready  = rst_n && !flush && (state == IDLE || (beat && out_last));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= IDLE;
            mask  <= '0;
            count <= '0;
            none  <= 1'b0;
        end else if (accept) begin
            state <= SCAN;
            mask  <= in_vec;
            count <= pop;
            none  <= (in_vec == '0);
        end else if (beat) begin
            mask  <= mask & ~(WIDTH'(1) << pick);
            state <= out_last ? IDLE : SCAN;
            none  <= out_last ? 1'b0 : none;
        end
    end
endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb_prio_scan_encoder: drives high-first and low-first instances in lockstep against a beat-queue model.
module tb_prio_scan_encoder;
    localparam int W  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_vec = '0;
    logic          rdy_h, val_h, last_h, none_h;
    logic          rdy_l, val_l, last_l, none_l;
    logic [IW-1:0] idx_h, idx_l;
    logic [IW:0]   cnt_h, cnt_l;

    prio_scan_encoder #(.WIDTH(W), .LOW_FIRST(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_h),
        .in_vec(in_vec), .out_valid(val_h), .out_ready(out_ready), .out_idx(idx_h),
        .out_last(last_h), .out_none(none_h), .out_count(cnt_h)
    );

    prio_scan_encoder #(.WIDTH(W), .LOW_FIRST(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_l),
        .in_vec(in_vec), .out_valid(val_l), .out_ready(out_ready), .out_idx(idx_l),
        .out_last(last_l), .out_none(none_l), .out_count(cnt_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        bit last;
        bit none;
        int cnt;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    bit    acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pending beats of a vector: set positions listed high-first and low-first.
    function automatic void push_vec(input logic [W-1:0] v);
        int   s[$];
        int   n;
        beat_t b;
        for (int i = 0; i < W; i++)
            if (v[i]) s.push_back(i);
        n = s.size();
        if (n == 0) begin
            b = '{hi: 0, lo: 0, last: 1'b1, none: 1'b1, cnt: 0};
            q.push_back(b);
        end
        for (int k = 0; k < n; k++) begin
            b = '{hi: s[n-1-k], lo: s[k], last: (k == n-1), none: 1'b0, cnt: n};
            q.push_back(b);
        end
    endfunction

    task automatic step(input logic r, input logic f, input logic iv, input logic [W-1:0] v,
                        input logic ordy, output bit accepted);
        bit    er, ev;
        beat_t b;
        @(negedge clk);
        rst_n = r; flush = f; in_valid = iv; in_vec = v; out_ready = ordy;
        #1;
        ev = r && (q.size() > 0);
        er = r && !f && (q.size() == 0 || (q.size() == 1 && ordy));
        b  = '{hi: 0, lo: 0, last: 1'b0, none: 1'b0, cnt: 0};
        if (ev) b = q[0];
        chk("in_ready_h", 32'(rdy_h), 32'(er));
        chk("in_ready_l", 32'(rdy_l), 32'(er));
        chk("out_valid_h", 32'(val_h), 32'(ev));
        chk("out_valid_l", 32'(val_l), 32'(ev));
        chk("out_idx_h", 32'(idx_h), 32'(b.hi));
        chk("out_idx_l", 32'(idx_l), 32'(b.lo));
        chk("out_last_h", 32'(last_h), 32'(b.last));
        chk("out_last_l", 32'(last_l), 32'(b.last));
        chk("out_none_h", 32'(none_h), 32'(b.none));
        chk("out_none_l", 32'(none_l), 32'(b.none));
        chk("out_count_h", 32'(cnt_h), 32'(b.cnt));
        chk("out_count_l", 32'(cnt_l), 32'(b.cnt));
        accepted = r && !f && iv && er;
        if (!r || f) q.delete();
        else begin
            if (ev && ordy) void'(q.pop_front());
            if (accepted) push_vec(v);
        end
    endtask

    task automatic send(input logic [W-1:0] v, input logic ordy);
        bit a;
        a = 1'b0;
        for (int n = 0; n < 60 && !a; n++) step(1'b1, 1'b0, 1'b1, v, ordy, a);
        if (!a) begin
            n_vec++; n_bad++;
            $error("FAIL send_timeout: observed not-accepted expected accepted vec %0h", v);
        end
    endtask

    task automatic drain(input int pct);
        bit a;
        for (int n = 0; n < 300 && q.size() > 0; n++)
            step(1'b1, 1'b0, 1'b0, '0, $urandom_range(99) < pct, a);
        if (q.size() > 0) begin
            n_vec++; n_bad++;
            $error("FAIL drain_timeout: observed %0d beats left expected 0", q.size());
        end
    endtask

    initial begin
        logic [W-1:0] rv;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        send(16'h8421, 1'b1);
        drain(100);
        send(16'h0000, 1'b1);
        drain(100);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        send(16'h0003, 1'b1);
        send(16'h0100, 1'b1);
        drain(100);
        send(16'hFFFF, 1'b1);
        drain(100);
        send(16'h8421, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
        drain(100);
        send(16'h8421, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        step(1'b1, 1'b1, 1'b1, 16'h00F0, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        send(16'h8421, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        step(1'b0, 1'b0, 1'b1, 16'h0F00, 1'b1, acc);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(4))
                0: rv = '0;
                1: rv = W'(1) << $urandom_range(W-1);
                2: rv = 16'hFFFF;
                default: rv = W'($urandom);
            endcase
            step($urandom_range(60) != 0, $urandom_range(30) == 0, $urandom_range(2) != 0,
                 rv, $urandom_range(3) != 0, acc);
        end
        drain(100);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
